fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
Parametrised PC/fetch-address generator for the pipelined MIPS core. It is the next generation of the F-stage PC register. It adds:
- configurable reset, exception and text-segment bounds;
- prioritised redirect sources: exception entry, ERET, branch/jump;
- a one-entry pending-redirect register, so a branch target produced while F is stalled is not lost.

It drives IM addressing and the F/D pipeline register, and flags fetch address errors for CP0.

Parameters:
ADDR_W, 32, PC/address width.
RESET_VEC, 32'h0000_3000, PC value after reset.
EXC_VEC, 32'h0000_4180, exception handler entry address.
TEXT_LO, 32'h0000_3000, lowest legal fetch address (inclusive).
TEXT_HI, 32'h0000_6ffc, highest legal fetch address (inclusive).
EXC_ADEL, 4, exccode reported for an illegal fetch address.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
stall  in  1  hazard unit holds F (PC must not advance sequentially).
br_valid  in  1  D-stage branch/jump resolved as taken this cycle.
br_target  in  ADDR_W  branch/jump destination.
exc_req  in  1  CP0 requests exception/interrupt entry.
eret_req  in  1  ERET committing; return to epc.
epc  in  ADDR_W  return address from CP0.
pc  out  ADDR_W  current fetch address (registered).
pc4  out  ADDR_W  pc + 4, modulo 2^ADDR_W.
exccode  out  5  EXC_ADEL if pc is illegal, else 0 (combinational from pc).
pend_valid  out  1  a redirect is latched and waiting for the stall to release.

Behaviour:
- Reset (async, immediate): pc=RESET_VEC, pend_valid=0, pend_target=0. Hence exccode=0 if RESET_VEC is legal, and pc4=RESET_VEC+4.
- pc updates only on the rising clk edge. Next-state priority, evaluated each cycle:
  1. exc_req: pc<=EXC_VEC; pend_valid<=0. Ignores stall.
  2. else eret_req: pc<=epc; pend_valid<=0. Ignores stall.
  3. else stall: pc holds. If br_valid: pend_valid<=1, pend_target<=br_target (a later br_valid overwrites an earlier one). Otherwise pending state holds.
  4. else br_valid: pc<=br_target; pend_valid<=0. A live branch beats a stale pending entry.
  5. else pend_valid: pc<=pend_target; pend_valid<=0.
  6. else: pc<=pc+4.
- Simultaneous events:
  - exc_req with eret_req: exception wins.
  - exc_req with br_valid or stall: exception wins and the branch is discarded.
- Latency: a redirect takes effect on the next edge. pc shows the new value one cycle after the request is sampled.
- Wrap-around: pc+4 wraps at 2^ADDR_W with no error flag of its own. The wrapped value is then flagged by the range check.
- exccode: illegal when any of pc[1:0]!=0, pc<TEXT_LO, or pc>TEXT_HI. Comparisons are unsigned, full ADDR_W.
  - pc still advances while exccode is nonzero. Stopping it is CP0's job via exc_req.
- Targets are not validated on entry. An illegal br_target or epc is loaded, then flagged through exccode.
- Reset asserted mid-stall or with a pending redirect: the pending entry is cleared immediately.
- No X propagation. Inputs other than the strobes are don't-care when their strobe is 0.

Decomposition:
- Shared package (cpu_defs): EXC_ADEL and the other exccode constants; default RESET_VEC, EXC_VEC, TEXT_LO, TEXT_HI.
- One natural sub-module, fetch_addr_check: combinational range/alignment check, pc -> exccode. It is reusable by the M-stage load/store address check with different bounds.
- pend_valid/pend_target and the priority mux stay in fetch_pc_unit.

Test Plan:
- Reset then 4 free-running cycles -> pc = 3000, 3004, 3008, 300c, 3010; exccode=0; pend_valid=0.
- At pc=3010, stall=1 for 3 cycles with br_valid=1, br_target=3400 in the 1st stall cycle -> pc holds 3010 and pend_valid=1. Release the stall -> next pc=3400, pend_valid=0, then 3404.
- During a stall, br_valid with 3400, then br_valid with 3500 the next cycle -> after release pc=3500. Separately: pending entry 3400, then br_valid=1 with 3600 in the release cycle -> pc=3600.
- exc_req=1 with stall=1, br_valid=1 (3400) -> pc=4180, pend_valid=0. Later eret_req=1 with epc=3014 -> pc=3014. exc_req and eret_req together -> pc=4180.
- br_target=3002 -> pc=3002, exccode=4. br_target=2ffc -> exccode=4. br_target=6ffc -> exccode=0, then 7000 -> exccode=4.
- Assert reset asynchronously mid-cycle while pend_valid=1 and pc=3abc -> pc=3000 and pend_valid=0 before the next clk edge.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: CP0 exception codes and default fetch address map.
package cpu_defs;

    localparam logic [4:0] EXCCODE_INT  = 5'd0;
    localparam logic [4:0] EXCCODE_ADEL = 5'd4;
    localparam logic [4:0] EXCCODE_ADES = 5'd5;
    localparam logic [4:0] EXCCODE_SYS  = 5'd8;
    localparam logic [4:0] EXCCODE_RI   = 5'd10;
    localparam logic [4:0] EXCCODE_OV   = 5'd12;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;
    localparam logic [31:0] DEF_TEXT_LO   = 32'h0000_3000;
    localparam logic [31:0] DEF_TEXT_HI   = 32'h0000_6ffc;

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational word-alignment and window check of an address; reports
// EXC_CODE when the address is misaligned or outside [LO, HI].
module fetch_addr_check
    import cpu_defs::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] LO     = ADDR_W'(DEF_TEXT_LO),
    parameter logic [ADDR_W-1:0] HI     = ADDR_W'(DEF_TEXT_HI),
    parameter logic [4:0]      EXC_CODE = EXCCODE_ADEL
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [4:0]        exccode
);

    logic illegal_s;

    // Classify the address and select the reported code.
    always_comb begin
        illegal_s = (addr[1:0] != 2'b00) || (addr < LO) || (addr > HI);
        if (illegal_s) begin
            exccode = EXC_CODE;
        end else begin
            exccode = 5'd0;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// F-stage PC generator with prioritised redirects (exception, ERET, branch)
// and a one-entry pending redirect that survives fetch stalls.
module fetch_pc_unit
    import cpu_defs::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEF_EXC_VEC),
    parameter logic [ADDR_W-1:0] TEXT_LO   = ADDR_W'(DEF_TEXT_LO),
    parameter logic [ADDR_W-1:0] TEXT_HI   = ADDR_W'(DEF_TEXT_HI),
    parameter logic [4:0]        EXC_ADEL  = EXCCODE_ADEL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              exc_req,
    input  logic              eret_req,
    input  logic [ADDR_W-1:0] epc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc4,
    output logic [4:0]        exccode,
    output logic              pend_valid
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pend_target_r;
    logic              pend_valid_r;
    logic [ADDR_W-1:0] pc_nxt_s;
    logic [ADDR_W-1:0] pend_target_nxt_s;
    logic              pend_valid_nxt_s;
    logic [ADDR_W-1:0] pc4_s;

    assign pc4_s      = pc_r + PC_STEP;
    assign pc         = pc_r;
    assign pc4        = pc4_s;
    assign pend_valid = pend_valid_r;

    // Next-state priority: exception, ERET, stall (capture branch), live branch, pending, sequential.
    always_comb begin
        pc_nxt_s          = pc_r;
        pend_valid_nxt_s  = pend_valid_r;
        pend_target_nxt_s = pend_target_r;
        if (exc_req) begin
            pc_nxt_s         = EXC_VEC;
            pend_valid_nxt_s = 1'b0;
        end else if (eret_req) begin
            pc_nxt_s         = epc;
            pend_valid_nxt_s = 1'b0;
        end else if (stall) begin
            if (br_valid) begin
                pend_valid_nxt_s  = 1'b1;
                pend_target_nxt_s = br_target;
            end else begin
                pend_valid_nxt_s  = pend_valid_r;
                pend_target_nxt_s = pend_target_r;
            end
        end else if (br_valid) begin
            // A live branch is newer than anything held in the pending entry.
            pc_nxt_s         = br_target;
            pend_valid_nxt_s = 1'b0;
        end else if (pend_valid_r) begin
            pc_nxt_s         = pend_target_r;
            pend_valid_nxt_s = 1'b0;
        end else begin
            pc_nxt_s = pc4_s;
        end
    end

    // PC and pending-redirect state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r          <= RESET_VEC;
            pend_valid_r  <= 1'b0;
            pend_target_r <= {ADDR_W{1'b0}};
        end else begin
            pc_r          <= pc_nxt_s;
            pend_valid_r  <= pend_valid_nxt_s;
            pend_target_r <= pend_target_nxt_s;
        end
    end

    fetch_addr_check #(
        .ADDR_W   (ADDR_W),
        .LO       (TEXT_LO),
        .HI       (TEXT_HI),
        .EXC_CODE (EXC_ADEL)
    ) u_addr_check (
        .addr    (pc_r),
        .exccode (exccode)
    );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed plus randomized bench for fetch_pc_unit against a behavioural model.
module tb_fetch_pc_unit;

    localparam logic [31:0] R_VEC = 32'h0000_3000;
    localparam logic [31:0] E_VEC = 32'h0000_4180;
    localparam logic [31:0] T_LO  = 32'h0000_3000;
    localparam logic [31:0] T_HI  = 32'h0000_6ffc;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_valid;
    logic [31:0] br_target;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [4:0]  exccode;
    logic        pend_valid;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_tgt;
    logic        m_pend;

    fetch_pc_unit dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .exc_req    (exc_req),
        .eret_req   (eret_req),
        .epc        (epc),
        .pc         (pc),
        .pc4        (pc4),
        .exccode    (exccode),
        .pend_valid (pend_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] exp_code(input logic [31:0] a);
        if ((a % 32'd4) != 32'd0 || a < T_LO || a > T_HI) return 5'd4;
        return 5'd0;
    endfunction

    task automatic model_reset();
        m_pc   = R_VEC;
        m_pend = 1'b0;
        m_tgt  = 32'd0;
    endtask

    task automatic model_edge();
        if (exc_req) begin
            m_pc = E_VEC; m_pend = 1'b0;
        end else if (eret_req) begin
            m_pc = epc; m_pend = 1'b0;
        end else if (stall) begin
            if (br_valid) begin m_pend = 1'b1; m_tgt = br_target; end
        end else if (br_valid) begin
            m_pc = br_target; m_pend = 1'b0;
        end else if (m_pend) begin
            m_pc = m_tgt; m_pend = 1'b0;
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] e_pc4;
        e_pc4 = m_pc + 32'd4;
        compared++;
        assert (pc === m_pc) else begin
            mismatched++;
            $error("FAIL %s.pc observed=%h expected=%h", tag, pc, m_pc);
        end
        compared++;
        assert (pc4 === e_pc4) else begin
            mismatched++;
            $error("FAIL %s.pc4 observed=%h expected=%h", tag, pc4, e_pc4);
        end
        compared++;
        assert (exccode === exp_code(m_pc)) else begin
            mismatched++;
            $error("FAIL %s.exccode observed=%0d expected=%0d", tag, exccode, exp_code(m_pc));
        end
        compared++;
        assert (pend_valid === m_pend) else begin
            mismatched++;
            $error("FAIL %s.pend_valid observed=%b expected=%b", tag, pend_valid, m_pend);
        end
    endtask

    task automatic step(input string tag, input logic s, input logic bv, input logic [31:0] bt,
                        input logic e, input logic r, input logic [31:0] ep);
        stall = s; br_valid = bv; br_target = bt; exc_req = e; eret_req = r; epc = ep;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return $urandom;
        return T_LO + 32'd4 * 32'($urandom_range(0, 32'h0fff));
    endfunction

    initial begin
        reset = 1'b1; stall = 1'b0; br_valid = 1'b0; br_target = 32'd0;
        exc_req = 1'b0; eret_req = 1'b0; epc = 32'd0;
        model_reset();
        #12;
        check_all("reset");
        #5 reset = 1'b0;

        for (int i = 0; i < 4; i++) step("seq", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

        step("stall_br",  1'b1, 1'b1, 32'h3400, 1'b0, 1'b0, 32'd0);
        step("stall2",    1'b1, 1'b0, 32'd0,    1'b0, 1'b0, 32'd0);
        step("stall3",    1'b1, 1'b0, 32'd0,    1'b0, 1'b0, 32'd0);
        step("release",   1'b0, 1'b0, 32'd0,    1'b0, 1'b0, 32'd0);
        step("after_rel", 1'b0, 1'b0, 32'd0,    1'b0, 1'b0, 32'd0);

        step("ovw1",     1'b1, 1'b1, 32'h3400, 1'b0, 1'b0, 32'd0);
        step("ovw2",     1'b1, 1'b1, 32'h3500, 1'b0, 1'b0, 32'd0);
        step("ovw_rel",  1'b0, 1'b0, 32'd0,    1'b0, 1'b0, 32'd0);
        step("live1",    1'b1, 1'b1, 32'h3400, 1'b0, 1'b0, 32'd0);
        step("live_rel", 1'b0, 1'b1, 32'h3600, 1'b0, 1'b0, 32'd0);

        step("pre_exc",  1'b1, 1'b1, 32'h3400, 1'b0, 1'b0, 32'd0);
        step("exc",      1'b1, 1'b1, 32'h3400, 1'b1, 1'b0, 32'd0);
        step("eret",     1'b0, 1'b0, 32'd0,    1'b0, 1'b1, 32'h3014);
        step("exc_eret", 1'b0, 1'b0, 32'd0,    1'b1, 1'b1, 32'h3014);

        step("mis",      1'b0, 1'b1, 32'h3002, 1'b0, 1'b0, 32'd0);
        step("below",    1'b0, 1'b1, 32'h2ffc, 1'b0, 1'b0, 32'd0);
        step("top",      1'b0, 1'b1, 32'h6ffc, 1'b0, 1'b0, 32'd0);
        step("above",    1'b0, 1'b0, 32'd0,    1'b0, 1'b0, 32'd0);
        step("wrap_pre", 1'b0, 1'b1, 32'hffff_fffc, 1'b0, 1'b0, 32'd0);
        step("wrap",     1'b0, 1'b0, 32'd0,    1'b0, 1'b0, 32'd0);

        step("ar_br",    1'b0, 1'b1, 32'h3abc, 1'b0, 1'b0, 32'd0);
        step("ar_pend",  1'b1, 1'b1, 32'h3400, 1'b0, 1'b0, 32'd0);
        #2 reset = 1'b1;
        model_reset();
        #1 check_all("async_rst");
        #2 reset = 1'b0;
        step("post_rst", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            step("rand", ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), rand_addr(),
                 (r < 5), (r >= 5 && r < 10), rand_addr());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
